// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock
//   24-hour BCD time-of-day clock with NUM_ALARMS programmable alarm slots, a per-second
//   tick prescaler, once-per-minute-match alarm firing, snooze and load validation.
//
// Ports
//   clk                 system clock, all state updates on the rising edge
//   reset               synchronous active-high reset
//   H_in1/H_in0         hours tens/units digits for a load
//   M_in1/M_in0         minutes tens/units digits for a load
//   LD_time             load the time-of-day from the H_in*/M_in* digits
//   LD_alarm            load alarm slot alarm_sel from the H_in*/M_in* digits
//   alarm_sel           slot written by LD_alarm
//   AL_EN               per-slot arm enable
//   STOP_al             cancel a ringing alarm and any pending snooze
//   SNOOZE              snooze a ringing alarm
//   Alarm               alarm ringing
//   alarm_id            slot that caused the current or last ring
//   snooze_pend         snooze re-ring pending
//   load_err            one-cycle pulse when a load is rejected
//   sec_tick            one-cycle pulse on each seconds advance
//   H_out*/M_out*/S_out* current time digits
module multi_alarm_clock #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [2:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [IDX_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] AL_EN,
  input  logic                  STOP_al,
  input  logic                  SNOOZE,
  output logic                  Alarm,
  output logic [IDX_W-1:0]      alarm_id,
  output logic                  snooze_pend,
  output logic                  load_err,
  output logic                  sec_tick,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [2:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [2:0]            S_out1,
  output logic [3:0]            S_out0
);

  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
  // Snooze delay split into BCD digits so the target can be formed with a BCD add.
  localparam logic [2:0] SnzT = 3'(SNOOZE_MIN / 10);
  localparam logic [3:0] SnzU = 4'(SNOOZE_MIN % 10);

  // Time-of-day and prescaler
  logic [1:0]    h1_q, h1_d;
  logic [3:0]    h0_q, h0_d;
  logic [2:0]    m1_q, m1_d;
  logic [3:0]    m0_q, m0_d;
  logic [2:0]    s1_q, s1_d;
  logic [3:0]    s0_q, s0_d;
  logic [PW-1:0] presc_q, presc_d;

  // Alarm slots
  logic [NUM_ALARMS-1:0][1:0] al_h1_q, al_h1_d;
  logic [NUM_ALARMS-1:0][3:0] al_h0_q, al_h0_d;
  logic [NUM_ALARMS-1:0][2:0] al_m1_q, al_m1_d;
  logic [NUM_ALARMS-1:0][3:0] al_m0_q, al_m0_d;

  // Ring / snooze state
  logic             alarm_q, alarm_d;
  logic [IDX_W-1:0] alarm_id_q, alarm_id_d;
  logic             snooze_pend_q, snooze_pend_d;
  logic [1:0]       snz_h1_q, snz_h1_d;
  logic [3:0]       snz_h0_q, snz_h0_d;
  logic [2:0]       snz_m1_q, snz_m1_d;
  logic [3:0]       snz_m0_q, snz_m0_d;
  logic             load_err_q, load_err_d;
  logic             sec_tick_q, sec_tick_d;

  // Matches found on the advance into :00, applied on the following cycle.
  logic             match_q, match_d;
  logic [IDX_W-1:0] match_id_q, match_id_d;
  logic             snz_hit_q, snz_hit_d;

  // Load validation
  logic hm_valid, sel_ok, time_ok, alarm_ok;

  always_comb begin
    hm_valid = ((H_in1 < 2'd2) && (H_in0 <= 4'd9)) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3));
    hm_valid = hm_valid && (M_in1 <= 3'd5) && (M_in0 <= 4'd9);
    sel_ok   = 32'(alarm_sel) < NUM_ALARMS;
    time_ok  = LD_time && hm_valid;
    alarm_ok = LD_alarm && hm_valid && sel_ok;
    load_err_d = (LD_time && !hm_valid) || (LD_alarm && !(hm_valid && sel_ok));
  end

  // Prescaler and BCD time advance
  logic tick, sec_wrap;

  assign tick = (presc_q == PrescMax);

  always_comb begin
    h1_d       = h1_q;
    h0_d       = h0_q;
    m1_d       = m1_q;
    m0_d       = m0_q;
    s1_d       = s1_q;
    s0_d       = s0_q;
    presc_d    = presc_q;
    sec_tick_d = 1'b0;
    sec_wrap   = 1'b0;
    if (time_ok) begin
      // A load wins over a coincident tick; the second restarts cleanly.
      h1_d    = H_in1;
      h0_d    = H_in0;
      m1_d    = M_in1;
      m0_d    = M_in0;
      s1_d    = '0;
      s0_d    = '0;
      presc_d = '0;
    end else if (tick) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (s0_q == 4'd9) begin
        s0_d = '0;
        if (s1_q == 3'd5) begin
          s1_d     = '0;
          sec_wrap = 1'b1;
        end else begin
          s1_d = s1_q + 3'd1;
        end
      end else begin
        s0_d = s0_q + 4'd1;
      end
      if (sec_wrap) begin
        if (m0_q == 4'd9) begin
          m0_d = '0;
          if (m1_q == 3'd5) begin
            m1_d = '0;
            if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
              h1_d = '0;
              h0_d = '0;
            end else if (h0_q == 4'd9) begin
              h1_d = h1_q + 2'd1;
              h0_d = '0;
            end else begin
              h0_d = h0_q + 4'd1;
            end
          end else begin
            m1_d = m1_q + 3'd1;
          end
        end else begin
          m0_d = m0_q + 4'd1;
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Alarm slot writes
  always_comb begin
    al_h1_d = al_h1_q;
    al_h0_d = al_h0_q;
    al_m1_d = al_m1_q;
    al_m0_d = al_m0_q;
    for (int k = 0; k < int'(NUM_ALARMS); k++) begin
      if (alarm_ok && (alarm_sel == IDX_W'(k))) begin
        al_h1_d[k] = H_in1;
        al_h0_d[k] = H_in0;
        al_m1_d[k] = M_in1;
        al_m0_d[k] = M_in0;
      end
    end
  end

  // Match detection against the newly advanced time
  logic             any_match, snz_match;
  logic [IDX_W-1:0] low_id;

  always_comb begin
    any_match = 1'b0;
    low_id    = '0;
    // Descending scan so the lowest matching slot is the one left in low_id.
    for (int k = int'(NUM_ALARMS) - 1; k >= 0; k--) begin
      if (AL_EN[k] && (al_h1_q[k] == h1_d) && (al_h0_q[k] == h0_d) &&
          (al_m1_q[k] == m1_d) && (al_m0_q[k] == m0_d)) begin
        any_match = 1'b1;
        low_id    = IDX_W'(k);
      end
    end
    snz_match = snooze_pend_q && (snz_h1_q == h1_d) && (snz_h0_q == h0_d) &&
                (snz_m1_q == m1_d) && (snz_m0_q == m0_d);
  end

  // Snooze target: current H:M plus SNOOZE_MIN, as a BCD add with wrap at 24 h.
  // Digit arithmetic wraps in its native width; the final digit is always in range.
  logic       snz_c0, snz_c1;
  logic [3:0] tgt_m0;
  logic [2:0] tgt_m1;
  logic [1:0] tgt_h1;
  logic [3:0] tgt_h0;

  always_comb begin
    snz_c0 = ({1'b0, m0_q} + {1'b0, SnzU}) >= 5'd10;
    tgt_m0 = snz_c0 ? (m0_q + SnzU - 4'd10) : (m0_q + SnzU);
    snz_c1 = ({1'b0, m1_q} + {1'b0, SnzT} + {3'b0, snz_c0}) >= 4'd6;
    tgt_m1 = m1_q + SnzT + {2'b0, snz_c0} - (snz_c1 ? 3'd6 : 3'd0);
    tgt_h1 = h1_q;
    tgt_h0 = h0_q;
    if (snz_c1) begin
      if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
        tgt_h1 = '0;
        tgt_h0 = '0;
      end else if (h0_q == 4'd9) begin
        tgt_h1 = h1_q + 2'd1;
        tgt_h0 = '0;
      end else begin
        tgt_h0 = h0_q + 4'd1;
      end
    end
  end

  // Ring control: STOP_al > SNOOZE > match
  always_comb begin
    alarm_d       = alarm_q;
    alarm_id_d    = alarm_id_q;
    snooze_pend_d = snooze_pend_q;
    snz_h1_d      = snz_h1_q;
    snz_h0_d      = snz_h0_q;
    snz_m1_d      = snz_m1_q;
    snz_m0_d      = snz_m0_q;
    match_d       = 1'b0;
    match_id_d    = match_id_q;
    snz_hit_d     = 1'b0;
    if (STOP_al) begin
      // Any match detected now or waiting to be applied is dropped.
      alarm_d       = 1'b0;
      snooze_pend_d = 1'b0;
    end else if (SNOOZE && alarm_q) begin
      alarm_d       = 1'b0;
      snooze_pend_d = 1'b1;
      snz_h1_d      = tgt_h1;
      snz_h0_d      = tgt_h0;
      snz_m1_d      = tgt_m1;
      snz_m0_d      = tgt_m0;
    end else begin
      if (match_q) begin
        alarm_d    = 1'b1;
        alarm_id_d = match_id_q;
      end
      if (snz_hit_q) begin
        alarm_d       = 1'b1;
        snooze_pend_d = 1'b0;
      end
      match_d    = sec_wrap && any_match;
      match_id_d = low_id;
      snz_hit_d  = sec_wrap && snz_match;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h1_q          <= '0;
      h0_q          <= '0;
      m1_q          <= '0;
      m0_q          <= '0;
      s1_q          <= '0;
      s0_q          <= '0;
      presc_q       <= '0;
      al_h1_q       <= '0;
      al_h0_q       <= '0;
      al_m1_q       <= '0;
      al_m0_q       <= '0;
      alarm_q       <= 1'b0;
      alarm_id_q    <= '0;
      snooze_pend_q <= 1'b0;
      snz_h1_q      <= '0;
      snz_h0_q      <= '0;
      snz_m1_q      <= '0;
      snz_m0_q      <= '0;
      load_err_q    <= 1'b0;
      sec_tick_q    <= 1'b0;
      match_q       <= 1'b0;
      match_id_q    <= '0;
      snz_hit_q     <= 1'b0;
    end else begin
      h1_q          <= h1_d;
      h0_q          <= h0_d;
      m1_q          <= m1_d;
      m0_q          <= m0_d;
      s1_q          <= s1_d;
      s0_q          <= s0_d;
      presc_q       <= presc_d;
      al_h1_q       <= al_h1_d;
      al_h0_q       <= al_h0_d;
      al_m1_q       <= al_m1_d;
      al_m0_q       <= al_m0_d;
      alarm_q       <= alarm_d;
      alarm_id_q    <= alarm_id_d;
      snooze_pend_q <= snooze_pend_d;
      snz_h1_q      <= snz_h1_d;
      snz_h0_q      <= snz_h0_d;
      snz_m1_q      <= snz_m1_d;
      snz_m0_q      <= snz_m0_d;
      load_err_q    <= load_err_d;
      sec_tick_q    <= sec_tick_d;
      match_q       <= match_d;
      match_id_q    <= match_id_d;
      snz_hit_q     <= snz_hit_d;
    end
  end

  assign Alarm       = alarm_q;
  assign alarm_id    = alarm_id_q;
  assign snooze_pend = snooze_pend_q;
  assign load_err    = load_err_q;
  assign sec_tick    = sec_tick_q;
  assign H_out1      = h1_q;
  assign H_out0      = h0_q;
  assign M_out1      = m1_q;
  assign M_out0      = m0_q;
  assign S_out1      = s1_q;
  assign S_out0      = s0_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

  localparam int unsigned NA = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned TD = 4;
  localparam int unsigned SM = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    H_in1;
  logic [3:0]    H_in0;
  logic [2:0]    M_in1;
  logic [3:0]    M_in0;
  logic          LD_time, LD_alarm;
  logic [IW-1:0] alarm_sel;
  logic [NA-1:0] AL_EN;
  logic          STOP_al, SNOOZE;
  logic          Alarm;
  logic [IW-1:0] alarm_id;
  logic          snooze_pend, load_err, sec_tick;
  logic [1:0]    H_out1;
  logic [3:0]    H_out0;
  logic [2:0]    M_out1;
  logic [3:0]    M_out0;
  logic [2:0]    S_out1;
  logic [3:0]    S_out0;
  logic [19:0]   now;

  multi_alarm_clock #(
    .NUM_ALARMS(NA),
    .IDX_W     (IW),
    .TICK_DIV  (TD),
    .SNOOZE_MIN(SM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .H_in1      (H_in1),
    .H_in0      (H_in0),
    .M_in1      (M_in1),
    .M_in0      (M_in0),
    .LD_time    (LD_time),
    .LD_alarm   (LD_alarm),
    .alarm_sel  (alarm_sel),
    .AL_EN      (AL_EN),
    .STOP_al    (STOP_al),
    .SNOOZE     (SNOOZE),
    .Alarm      (Alarm),
    .alarm_id   (alarm_id),
    .snooze_pend(snooze_pend),
    .load_err   (load_err),
    .sec_tick   (sec_tick),
    .H_out1     (H_out1),
    .H_out0     (H_out0),
    .M_out1     (M_out1),
    .M_out0     (M_out0),
    .S_out1     (S_out1),
    .S_out0     (S_out0)
  );

  always #5 clk = ~clk;

  assign now = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected time word in the same digit packing as 'now'.
  function automatic logic [19:0] tm(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_dig(input int h1, input int h0, input int m1, input int m0);
    H_in1 = 2'(h1);
    H_in0 = 4'(h0);
    M_in1 = 3'(m1);
    M_in0 = 4'(m0);
  endtask

  task automatic load_time(input int h, input int m);
    set_dig(h / 10, h % 10, m / 10, m % 10);
    LD_time = 1'b1;
    step();
    LD_time = 1'b0;
  endtask

  task automatic load_alarm(input int sel, input int h, input int m);
    set_dig(h / 10, h % 10, m / 10, m % 10);
    alarm_sel = IW'(sel);
    LD_alarm  = 1'b1;
    step();
    LD_alarm  = 1'b0;
  endtask

  task automatic wait_alarm(input int max_cycles, input string name);
    int c = 0;
    while (Alarm !== 1'b1 && c < max_cycles) begin
      step();
      c++;
    end
    chk(name, 32'(Alarm), 32'd1);
  endtask

  typedef struct {
    logic        ldt;
    logic        lda;
    int          sel;
    int          h1, h0, m1, m0;
    logic        err;
    logic        tick;
    logic [19:0] t;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ldt, input logic lda, input int sel, input int h1,
                     input int h0, input int m1, input int m0, input logic err,
                     input logic tick, input logic [19:0] t);
    vec_t v;
    v.ldt = ldt; v.lda = lda; v.sel = sel;
    v.h1 = h1; v.h0 = h0; v.m1 = m1; v.m0 = m0;
    v.err = err; v.tick = tick; v.t = t;
    tbl.push_back(v);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
    alarm_sel = '0; AL_EN = '0;
    set_dig(0, 0, 0, 0);
    steps(2);
    reset = 1'b0;

    chk("reset_time", 32'(now), 32'(tm(0, 0, 0)));
    chk("reset_alarm", 32'(Alarm), 32'd0);
    chk("reset_id", 32'(alarm_id), 32'd0);
    chk("reset_pend", 32'(snooze_pend), 32'd0);
    chk("reset_err", 32'(load_err), 32'd0);
    chk("reset_tick", 32'(sec_tick), 32'd0);

    // Loads, validation and prescaler interaction (TICK_DIV = 4, prescaler starts at 0).
    add(1, 0, 0, 1, 2, 3, 4,  0, 0, tm(12, 34, 0));  // valid load
    add(1, 0, 0, 2, 4, 0, 0,  1, 0, tm(12, 34, 0));  // 24:00
    add(1, 0, 0, 1, 9, 6, 0,  1, 0, tm(12, 34, 0));  // 19:60
    add(1, 0, 0, 1, 10, 0, 0, 1, 0, tm(12, 34, 0));  // hours units 10
    add(1, 0, 0, 1, 2, 0, 0,  0, 0, tm(12, 0, 0));   // load on prescaler wrap
    add(0, 1, 5, 0, 6, 3, 0,  1, 0, tm(12, 0, 0));   // slot index out of range
    add(0, 1, 1, 3, 0, 0, 0,  1, 0, tm(12, 0, 0));   // hours tens 3
    add(1, 0, 0, 0, 9, 5, 10, 1, 0, tm(12, 0, 0));   // minutes units 10
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, tm(12, 0, 1));   // first tick after reload
    add(1, 1, 0, 0, 7, 1, 5,  0, 0, tm(7, 15, 0));   // both loads valid
    add(1, 1, 4, 0, 7, 4, 5,  1, 0, tm(7, 45, 0));   // time ok, slot rejected
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, tm(7, 45, 0));
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, tm(7, 45, 0));
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, tm(7, 45, 0));
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, tm(7, 45, 1));

    foreach (tbl[i]) begin
      LD_time   = tbl[i].ldt;
      LD_alarm  = tbl[i].lda;
      alarm_sel = IW'(tbl[i].sel);
      set_dig(tbl[i].h1, tbl[i].h0, tbl[i].m1, tbl[i].m0);
      step();
      chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_tick", i), 32'(sec_tick), 32'(tbl[i].tick));
      chk($sformatf("vec%0d_time", i), 32'(now), 32'(tbl[i].t));
    end
    LD_time = 1'b0;
    LD_alarm = 1'b0;

    // Full rollover 23:59:00 -> 00:00:00 over 60 seconds.
    load_time(23, 59);
    bad = 0;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (sec_tick !== ((i % 4) == 0)) bad++;
      if (i == 36)  chk("roll_09", 32'(now), 32'(tm(23, 59, 9)));
      if (i == 40)  chk("roll_10", 32'(now), 32'(tm(23, 59, 10)));
      if (i == 236) chk("roll_59", 32'(now), 32'(tm(23, 59, 59)));
    end
    chk("roll_tick_pattern", 32'(bad), 32'd0);
    chk("roll_midnight", 32'(now), 32'(tm(0, 0, 0)));

    // Two slots at 06:30, lowest armed index wins.
    AL_EN = 4'b0110;
    load_alarm(1, 6, 30);
    load_alarm(2, 6, 30);
    load_time(6, 29);
    steps(236);
    chk("m_pre_time", 32'(now), 32'(tm(6, 29, 59)));
    chk("m_pre_alarm", 32'(Alarm), 32'd0);
    steps(4);
    chk("m_edge_time", 32'(now), 32'(tm(6, 30, 0)));
    chk("m_edge_alarm", 32'(Alarm), 32'd0);
    step();
    chk("m_ring", 32'(Alarm), 32'd1);
    chk("m_id", 32'(alarm_id), 32'd1);
    AL_EN = 4'b0000;
    step();
    chk("m_disarm_keeps", 32'(Alarm), 32'd1);
    AL_EN = 4'b0110;
    STOP_al = 1'b1;
    step();
    STOP_al = 1'b0;
    chk("m_stop", 32'(Alarm), 32'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (Alarm !== 1'b0) bad++;
    end
    chk("m_no_refire", 32'(bad), 32'd0);

    // STOP_al coinciding with the match is discarded.
    load_time(6, 29);
    steps(236);
    steps(3);
    STOP_al = 1'b1;
    step();
    chk("stopm_time", 32'(now), 32'(tm(6, 30, 0)));
    step();
    STOP_al = 1'b0;
    chk("stopm_alarm0", 32'(Alarm), 32'd0);
    step();
    chk("stopm_alarm1", 32'(Alarm), 32'd0);

    // SNOOZE while idle is ignored.
    SNOOZE = 1'b1;
    step();
    SNOOZE = 1'b0;
    chk("snz_idle", 32'(snooze_pend), 32'd0);

    // Snooze from 23:58 wraps to 00:03.
    AL_EN = 4'b0001;
    load_alarm(0, 23, 58);
    load_time(23, 57);
    steps(240);
    chk("s_pre", 32'(Alarm), 32'd0);
    step();
    chk("s_ring", 32'(Alarm), 32'd1);
    chk("s_id", 32'(alarm_id), 32'd0);
    SNOOZE = 1'b1;
    step();
    SNOOZE = 1'b0;
    chk("s_snz_alarm", 32'(Alarm), 32'd0);
    chk("s_snz_pend", 32'(snooze_pend), 32'd1);
    wait_alarm(1500, "s_rering");
    chk("s_rering_time", 32'(now), 32'(tm(0, 3, 0)));
    chk("s_rering_id", 32'(alarm_id), 32'd0);
    chk("s_rering_pend", 32'(snooze_pend), 32'd0);
    STOP_al = 1'b1;
    step();
    STOP_al = 1'b0;
    chk("s_stop_alarm", 32'(Alarm), 32'd0);
    chk("s_stop_pend", 32'(snooze_pend), 32'd0);

    // Reset while ringing with a snooze pending.
    load_alarm(0, 0, 5);
    load_time(0, 4);
    steps(241);
    chk("r_ring", 32'(Alarm), 32'd1);
    SNOOZE = 1'b1;
    step();
    SNOOZE = 1'b0;
    load_alarm(1, 0, 6);
    AL_EN = 4'b0011;
    wait_alarm(400, "r_ring2");
    chk("r_id2", 32'(alarm_id), 32'd1);
    chk("r_pend2", 32'(snooze_pend), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_alarm", 32'(Alarm), 32'd0);
    chk("r_id", 32'(alarm_id), 32'd0);
    chk("r_pend", 32'(snooze_pend), 32'd0);
    chk("r_time", 32'(now), 32'(tm(0, 0, 0)));
    chk("r_tick", 32'(sec_tick), 32'd0);
    chk("r_err", 32'(load_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
